// File: rtl/shift_add_mult_ctrl.sv
// -----------------------------------------------------------------------------
// shift_add_mult_ctrl
//
// Unsigned 8x8 -> 16-bit multiplier built from one 8-bit ripple-carry adder
// that is reused over eight add-and-shift iterations. This block owns the
// operand, accumulator and multiplier registers, the iteration counter and
// the start/busy/done handshake.
//
// Ports:
//   clk    in   1   single clock, rising edge
//   reset  in   1   synchronous, active-high
//   start  in   1   multiply request, accepted in IDLE or DONE
//   A      in   8   multiplicand, latched on acceptance
//   B      in   8   multiplier, latched on acceptance
//   P      out 16   product, registered, held until the next completed result
//   busy   out  1   high during the eight iterations
//   done   out  1   one-cycle pulse when P holds a new result
//
// State table:
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | one add-and-shift iteration per edge, eight in total
//   DONE    | P just updated; start here reloads and runs back-to-back
// -----------------------------------------------------------------------------
module shift_add_mult_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_m;
    logic [7:0]  r_q;
    logic [7:0]  r_acc;
    logic [2:0]  r_cnt;
    logic [15:0] r_p;

    logic        w_load;
    logic        w_step;
    logic        w_last;

    // Shared ripple-carry adder: ACC + M, carry-in tied low.
    logic [8:0]  w_carry;
    logic [7:0]  w_sum;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < 8; i++) begin : g_rca
        assign w_sum[i]       = r_acc[i] ^ r_m[i] ^ w_carry[i];
        assign w_carry[i + 1] = (r_acc[i] & r_m[i]) | (w_carry[i] & (r_acc[i] ^ r_m[i]));
    end

    // One iteration: conditional add into {C,ACC}, then shift {C,ACC,Q}
    // right by one. The carry C only exists between the add and the shift:
    // the shift always moves it into ACC[7] and leaves a zero behind, so it
    // never needs to survive across an edge.
    logic        w_add_c;
    logic [7:0]  w_add_acc;
    logic [7:0]  w_acc_nxt;
    logic [7:0]  w_q_nxt;

    always_comb begin
        w_add_c   = 1'b0;
        w_add_acc = r_acc;
        if (r_q[0]) begin
            w_add_c   = w_carry[8];
            w_add_acc = w_sum;
        end
        w_acc_nxt = {w_add_c, w_add_acc[7:1]};
        w_q_nxt   = {w_add_acc[0], r_q[7:1]};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == 3'd7) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m   <= 8'd0;
            r_q   <= 8'd0;
            r_acc <= 8'd0;
            r_cnt <= 3'd0;
            r_p   <= 16'd0;
        end else if (w_load) begin
            r_m   <= A;
            r_q   <= B;
            r_acc <= 8'd0;
            r_cnt <= 3'd0;
        end else if (w_step) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 3'd1;
            if (w_last) begin
                r_p <= {w_acc_nxt, w_q_nxt};
            end
        end
    end

    assign P    = r_p;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule
